// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 16-bit shifter between two requesters; accept->resp_valid 2 cycles.
// Requests are blocked (ready low) from accept until the response handshake; the response is held until resp_ready.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_opcode,
    input  logic [15:0] req0_a,
    input  logic [3:0]  req0_amt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_opcode,
    input  logic [15:0] req1_a,
    input  logic [3:0]  req1_amt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [15:0] a;
        logic [3:0]  amt;
    } op_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;

    state_t      state, state_nxt;
    op_t         op_q;
    logic        id_q;
    logic        last_grant;
    logic [15:0] resp_data_q;

    logic        grant_vld;
    logic        grant_id;
    logic        accept;
    op_t         op_sel;

    logic [15:0] shift_b;
    logic [15:0] shift_out;
    logic [31:0] rot_wide;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && grant_vld) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    accept     = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        if (grant_id) begin
            op_sel = '{opcode: req1_opcode, a: req1_a, amt: req1_amt};
        end else begin
            op_sel = '{opcode: req0_opcode, a: req0_a, amt: req0_amt};
        end
    end

    // The single shared shifter, always fed from the latched operands.
    always_comb begin
        shift_b  = {12'd0, op_q.amt};
        rot_wide = {op_q.a, op_q.a} >> shift_b[3:0];
        case (op_q.opcode)
            OP_SLL:  shift_out = op_q.a << shift_b[3:0];
            OP_SRA:  shift_out = $unsigned($signed(op_q.a) >>> shift_b[3:0]);
            OP_ROR:  shift_out = rot_wide[15:0];
            default: shift_out = op_q.a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            id_q        <= 1'b0;
            last_grant  <= 1'b1;
            resp_data_q <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= op_sel;
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                resp_data_q <= shift_out;
            end
        end
    end

    assign resp_valid = (state == RESP);
    assign resp_id    = id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state != IDLE);

endmodule
